// File: rtl/pc_adder.sv
// Next-program-counter select and register for instruction fetch.
// Priority: halt holds pc_in, then branch target, else sequential increment.
module pc_adder #(
  parameter int INST_ADDR_WIDTH = 16,
  parameter int PC_INCREMENT    = 1,
  parameter int RESET_PC        = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_ADDR_WIDTH-1:0] pc_in,
  input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
  input  logic                       halt,
  input  logic                       branch,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic                       halted
);

  localparam logic [INST_ADDR_WIDTH-1:0] INC_VAL   = INST_ADDR_WIDTH'(PC_INCREMENT);
  localparam logic [INST_ADDR_WIDTH-1:0] RESET_VAL = INST_ADDR_WIDTH'(RESET_PC);

  logic [INST_ADDR_WIDTH-1:0] pc_d, pc_q;
  logic                       halted_d, halted_q;

  // Sum is truncated to the bus width, so the PC wraps modulo 2^W.
  always_comb begin
    pc_d     = pc_in + INC_VAL;
    halted_d = halt;
    if (halt) begin
      pc_d = pc_in;
    end else if (branch) begin
      pc_d = branch_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VAL;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_pc_adder.sv
// Scoreboard bench for pc_adder: one DUT with default increment, one with
// increment 2, driven by shared directed vectors with hand-computed results.
module tb_pc_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in, branch_addr;
  logic        halt, branch;
  logic [15:0] pc_out1, pc_out2;
  logic        halted1, halted2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] pc1;
    logic [15:0] pc2;
    logic        hl;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] ba;
    logic        h;
    logic        b;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eh;
  } vec_t;

  always #5 clk = ~clk;

  pc_adder #(.INST_ADDR_WIDTH(16), .PC_INCREMENT(1), .RESET_PC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .branch_addr(branch_addr),
    .halt(halt), .branch(branch), .pc_out(pc_out1), .halted(halted1)
  );

  pc_adder #(.INST_ADDR_WIDTH(16), .PC_INCREMENT(2), .RESET_PC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .branch_addr(branch_addr),
    .halt(halt), .branch(branch), .pc_out(pc_out2), .halted(halted2)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle one edge after the inputs were applied.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, " pc_out"},   pc_out1,         e.pc1);
      check({e.name, " pc_out2"},  pc_out2,         e.pc2);
      check({e.name, " halted"},   {15'd0, halted1}, {15'd0, e.hl});
      check({e.name, " halted2"},  {15'd0, halted2}, {15'd0, e.hl});
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    pc_in       = v.pc;
    branch_addr = v.ba;
    halt        = v.h;
    branch      = v.b;
    e.name = v.name; e.pc1 = v.e1; e.pc2 = v.e2; e.hl = v.eh;
    sb.push_back(e);
  endtask

  task automatic drain();
    int budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain timeout: %0d entries left, expected 0", sb.size());
    end
  endtask

  vec_t vecs_a[$];
  vec_t vecs_b[$];

  initial begin
    vecs_a = '{
      '{"release",    16'd10,    16'd500, 1'b0, 1'b0, 16'd11,    16'd12,    1'b0},
      '{"seq",        16'd11,    16'd500, 1'b0, 1'b0, 16'd12,    16'd13,    1'b0},
      '{"branch",     16'd11,    16'd500, 1'b0, 1'b1, 16'd500,   16'd500,   1'b0},
      '{"after_br",   16'd500,   16'd500, 1'b0, 1'b0, 16'd501,   16'd502,   1'b0},
      '{"halt_prio",  16'd501,   16'd500, 1'b1, 1'b1, 16'd501,   16'd501,   1'b1},
      '{"halt_again", 16'd501,   16'd500, 1'b1, 1'b0, 16'd501,   16'd501,   1'b1},
      '{"unhalt_br",  16'd501,   16'd500, 1'b0, 1'b1, 16'd500,   16'd500,   1'b0},
      '{"wrap",       16'hFFFF,  16'd500, 1'b0, 1'b0, 16'h0000,  16'h0001,  1'b0},
      '{"near_wrap",  16'hFFFE,  16'd500, 1'b0, 1'b0, 16'hFFFF,  16'h0000,  1'b0},
      '{"halt_top",   16'hFFFF,  16'd500, 1'b1, 1'b0, 16'hFFFF,  16'hFFFF,  1'b1},
      '{"odd_target", 16'h1234,  16'hABCD,1'b0, 1'b1, 16'hABCD,  16'hABCD,  1'b0},
      '{"to_500",     16'd7,     16'd500, 1'b0, 1'b1, 16'd500,   16'd500,   1'b0}
    };
    vecs_b = '{
      '{"post_rst",   16'd0,     16'd500, 1'b0, 1'b0, 16'd1,     16'd2,     1'b0},
      '{"post_rst2",  16'd1,     16'd500, 1'b0, 1'b0, 16'd2,     16'd3,     1'b0}
    };

    rst_n = 1'b0; pc_in = 16'd10; branch_addr = 16'd500; halt = 1'b0; branch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pc_out",  pc_out1, 16'd0);
    check("reset pc_out2", pc_out2, 16'd0);
    check("reset halted",  {15'd0, halted1}, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs_a[i]) issue(vecs_a[i]);
    drain();

    // Asynchronous reset pulse between edges, then resume from pc_in=0.
    #1;
    rst_n = 1'b0;
    #1;
    check("async pc_out",  pc_out1, 16'd0);
    check("async pc_out2", pc_out2, 16'd0);
    check("async halted",  {15'd0, halted1}, 16'd0);
    #1;
    rst_n = 1'b1;
    foreach (vecs_b[i]) issue(vecs_b[i]);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
